armleocpu_axi_lite_initiator: RTL and testbench
===============================================

Name: armleocpu_axi_lite_initiator

Overview:
- Single-outstanding AXI4-Lite initiator (master): converts a simple valid/ready command interface into AXI4-Lite read or write transactions and returns one response per command.
- Lets CPU-side or debug logic reach AXI4-Lite peripherals (timer/interrupt controller and similar) over the same 16-bit-address, 32-bit-data bus those peripherals expose.
- Misaligned commands are rejected locally and generate no bus traffic.

Parameters:
- ADDR_WIDTH, 16, width of req_addr and the AXI address buses.
- CHECK_ALIGN, 1, when 1, a command with req_addr[1:0] != 0 is answered locally with SLVERR (2'b10); when 0, it is issued to the bus unchanged.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  command valid.
- req_ready  output  1  command accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  write data.
- req_wstrb  input  4  write byte strobes.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  output  32  read data (0 for writes and local errors).
- rsp_resp  output  2  AXI response code (BRESP, RRESP or local 2'b10).
- AXI_AWADDR  output  ADDR_WIDTH  write address.
- AXI_AWVALID  output  1  write address valid.
- AXI_AWREADY  input  1  write address ready.
- AXI_WDATA  output  32  write data.
- AXI_WSTRB  output  4  write strobes.
- AXI_WVALID  output  1  write data valid.
- AXI_WREADY  input  1  write data ready.
- AXI_BRESP  input  2  write response.
- AXI_BVALID  input  1  write response valid.
- AXI_BREADY  output  1  write response ready.
- AXI_ARADDR  output  ADDR_WIDTH  read address.
- AXI_ARVALID  output  1  read address valid.
- AXI_ARREADY  input  1  read address ready.
- AXI_RDATA  input  32  read data.
- AXI_RRESP  input  2  read response.
- AXI_RVALID  input  1  read data valid.
- AXI_RREADY  output  1  read data ready.

Behaviour:
- States: IDLE, WRITE_ADDR_DATA, WRITE_RESP, READ_ADDR, READ_DATA, RESPOND.
- Reset (asynchronous, any cycle, including mid-transaction):
  - state = IDLE.
  - All AXI valid/ready outputs = 0.
  - rsp_valid = 0; rsp_rdata = 0; rsp_resp = 0.
  - Address and data registers = 0.
  - An in-flight transaction is abandoned. The system resets the slave together with the initiator.
- Command acceptance:
  - req_ready = 1 only in IDLE (combinational from state).
  - On acceptance, req_addr, req_wdata and req_wstrb are latched.
  - Local error (CHECK_ALIGN=1 and req_addr[1:0] != 0) -> RESPOND next cycle with rsp_resp = 2'b10, rsp_rdata = 0. No AXI valid is asserted.
  - Otherwise, a write -> WRITE_ADDR_DATA and a read -> READ_ADDR.
- WRITE_ADDR_DATA:
  - AWVALID and WVALID both rise in the cycle after acceptance.
  - Each valid drops in the cycle after its own handshake (valid && ready at a clock edge). The two handshakes are tracked independently (aw_done, w_done) and may complete in either order or in the same cycle.
  - AWADDR, WDATA and WSTRB stay stable while their valid is high.
  - When both handshakes are done -> WRITE_RESP.
- WRITE_RESP:
  - BREADY = 1.
  - On BVALID: capture BRESP into rsp_resp, set rsp_rdata = 0, go to RESPOND.
- READ_ADDR:
  - ARVALID = 1 from the cycle after acceptance until the AR handshake; ARADDR stable.
  - After the handshake -> READ_DATA.
- READ_DATA:
  - RREADY = 1.
  - On RVALID: capture RDATA and RRESP, go to RESPOND.
- RESPOND:
  - rsp_valid = 1; rsp_rdata and rsp_resp held stable.
  - On rsp_ready -> IDLE; rsp_valid = 0 in the next cycle.
  - The next command can be accepted no earlier than the cycle after the response handshake (req_ready is 0 during RESPOND).
- Minimum latencies with always-ready slave and consumer, command accepted at cycle T:
  - Write: AW and W handshakes at T+1, BREADY at T+2, B at T+2 if BVALID is already high, rsp_valid at T+3.
  - Read: AR at T+1, R at T+2, rsp_valid at T+3.
- Protocol rules:
  - Never more than one outstanding transaction.
  - Never assert AXI_*VALID in IDLE or RESPOND.
  - BREADY/RREADY are 0 outside their states; a BVALID/RVALID arriving in another state is ignored.
- Response codes (00/10/11) are passed through from the slave unmodified.

Test Plan:
- Write 0x4000, data 0x12345678, wstrb 0xF, to an always-ready slave that returns BRESP 00 -> AWADDR 0x4000 and WDATA 0x12345678 handshake at T+1; rsp_valid at T+3 with rsp_resp 00 and rsp_rdata 0.
- Read 0xBFF8, slave returns RDATA 0x0000002A and RRESP 00 with ARREADY delayed 3 cycles -> ARVALID held 4 cycles with stable address; rsp_rdata 0x2A; rsp_resp 00.
- Write with AWREADY delayed 2 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID stays high until its handshake, BREADY rises only after both; one response only.
- Command to 0x4002 with CHECK_ALIGN=1 -> no AXI valid ever asserted; rsp_resp 2'b10 at T+1.
- Read of unmapped 0x8000 with RRESP 2'b11, rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata and rsp_resp stable throughout; req_ready 0 until the cycle after rsp_ready.
- Assert rst while AWVALID=1 -> AWVALID, WVALID and rsp_valid drop immediately (asynchronously); after release, req_ready = 1 and a fresh read completes normally.

Source files
------------

// File: rtl/armleocpu_axi_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: turns one valid/ready command into one
// AXI4-Lite read or write and returns exactly one response per command.
module armleocpu_axi_lite_initiator #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned CHECK_ALIGN = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,

  output logic [ADDR_WIDTH-1:0] AXI_AWADDR,
  output logic                  AXI_AWVALID,
  input  logic                  AXI_AWREADY,
  output logic [31:0]           AXI_WDATA,
  output logic [3:0]            AXI_WSTRB,
  output logic                  AXI_WVALID,
  input  logic                  AXI_WREADY,
  input  logic [1:0]            AXI_BRESP,
  input  logic                  AXI_BVALID,
  output logic                  AXI_BREADY,

  output logic [ADDR_WIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [31:0]           AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ADDR_DATA,
    WRITE_RESP,
    READ_ADDR,
    READ_DATA,
    RESPOND
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    misaligned;
  logic                    aw_hs;
  logic                    w_hs;

  assign req_ready  = (state == IDLE);
  assign misaligned = (CHECK_ALIGN != 0) && (req_addr[1:0] != 2'b00);
  assign aw_hs      = AXI_AWVALID && AXI_AWREADY;
  assign w_hs       = AXI_WVALID && AXI_WREADY;

  // One latched address serves both channels since only one transaction is ever in flight.
  assign AXI_AWADDR = addr_q;
  assign AXI_ARADDR = addr_q;
  assign AXI_WDATA  = wdata_q;
  assign AXI_WSTRB  = wstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      AXI_AWVALID <= 1'b0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (misaligned) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_resp  <= RESP_SLVERR;
              state     <= RESPOND;
            end else if (req_write) begin
              AXI_AWVALID <= 1'b1;
              AXI_WVALID  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WRITE_ADDR_DATA;
            end else begin
              AXI_ARVALID <= 1'b1;
              state       <= READ_ADDR;
            end
          end
        end

        // AW and W complete independently, in either order or together.
        WRITE_ADDR_DATA: begin
          if (aw_hs) begin
            AXI_AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            AXI_WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            AXI_BREADY <= 1'b1;
            state      <= WRITE_RESP;
          end
        end

        WRITE_RESP: begin
          if (AXI_BVALID) begin
            AXI_BREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_resp   <= AXI_BRESP;
            state      <= RESPOND;
          end
        end

        READ_ADDR: begin
          if (AXI_ARREADY) begin
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b1;
            state       <= READ_DATA;
          end
        end

        READ_DATA: begin
          if (AXI_RVALID) begin
            AXI_RREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= AXI_RDATA;
            rsp_resp   <= AXI_RRESP;
            state      <= RESPOND;
          end
        end

        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_axi_lite_initiator.sv
// Bench for armleocpu_axi_lite_initiator: directed latency/protocol cases plus
// random commands against a word-memory reference model and a random-latency slave.
module tb_armleocpu_axi_lite_initiator;

  localparam int unsigned AW      = 16;
  localparam int          TIMEOUT = 200;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AXI_AWADDR, AXI_ARADDR;
  logic          AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [31:0]   AXI_WDATA, AXI_RDATA;
  logic [3:0]    AXI_WSTRB;
  logic [1:0]    AXI_BRESP, AXI_RRESP;
  logic          AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;

  armleocpu_axi_lite_initiator #(.ADDR_WIDTH(AW), .CHECK_ALIGN(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Address map seen by both the slave and the reference model.
  function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
    if (a[15:12] == 4'h8)     return 2'b11;
    else if (a[5:2] == 4'hF)  return 2'b10;
    else                      return 2'b00;
  endfunction

  function automatic logic [31:0] init_val(input int k);
    return 32'h5A5A_0000 ^ 32'(k * 7919);
  endfunction

  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];

  function automatic logic [31:0] ref_get(input int k);
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_val(k);
  endfunction

  function automatic logic [31:0] slv_get(input int k);
    if (slv_mem.exists(k)) return slv_mem[k];
    return init_val(k);
  endfunction

  // Slave latency settings (cycles of valid before ready / before response); -1 = random 0..3.
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;

  function automatic int pick(input int lat);
    if (lat < 0) return int'($urandom_range(0, 3));
    return lat;
  endfunction

  // Per-command observations made by the slave.
  int aw_first = -1, ar_first = -1, aw_hs_c = -1, w_hs_c = -1, ar_hs_c = -1, bready_first = -1;
  int aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0;
  int axi_valid_cycles = 0, proto_err = 0, stable_err = 0;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wdata;
  logic [3:0]    exp_wstrb;

  // Behavioural AXI4-Lite slave: decides ready/valid at each falling edge.
  initial begin : axi_slave
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_cur, w_cur, ar_cur, b_cur, r_cur, k;
    bit aw_wait, w_wait, ar_wait, aw_have, w_have, ar_have;
    bit b_pend, b_start, b_active, b_fire, r_start, r_active, r_fire;
    logic [AW-1:0] aw_a, ar_a;
    logic [31:0]   w_d, r_data, word;
    logic [3:0]    w_s;
    logic [1:0]    b_resp, r_resp;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_cur = 0; w_cur = 0; ar_cur = 0; b_cur = 0; r_cur = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; aw_have = 0; w_have = 0; ar_have = 0;
    b_pend = 0; b_start = 0; b_active = 0; b_fire = 0; r_start = 0; r_active = 0; r_fire = 0;
    aw_a = '0; ar_a = '0; w_d = '0; w_s = '0; r_data = '0; b_resp = '0; r_resp = '0;
    AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0; AXI_BVALID = 0; AXI_RVALID = 0;
    AXI_BRESP = 0; AXI_RRESP = 0; AXI_RDATA = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; aw_have = 0; w_have = 0; ar_have = 0;
        b_pend = 0; b_start = 0; b_active = 0; b_fire = 0; r_start = 0; r_active = 0; r_fire = 0;
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0; AXI_BVALID = 0; AXI_RVALID = 0;
        AXI_BRESP = 0; AXI_RRESP = 0; AXI_RDATA = 0;
      end else begin
        if (AXI_AWVALID || AXI_WVALID || AXI_ARVALID) axi_valid_cycles++;
        if (rsp_valid && (AXI_AWVALID || AXI_WVALID || AXI_ARVALID)) proto_err++;
        if (b_fire) begin AXI_BVALID = 0; b_active = 0; b_pend = 0; aw_have = 0; w_have = 0; b_fire = 0; end
        if (r_fire) begin AXI_RVALID = 0; AXI_RDATA = 0; r_active = 0; ar_have = 0; r_fire = 0; end
        if (b_start) begin b_start = 0; b_active = 1; b_cnt = 0; b_cur = pick(b_lat); end
        if (r_start) begin r_start = 0; r_active = 1; r_cnt = 0; r_cur = pick(r_lat); end
        if (AXI_BREADY && !(aw_have && w_have)) proto_err++;
        if (AXI_RREADY && !ar_have) proto_err++;
        if (AXI_BREADY && bready_first < 0) bready_first = cyc;
        if (b_active && !AXI_BVALID) begin
          if (b_cnt >= b_cur) begin AXI_BVALID = 1; AXI_BRESP = b_resp; end else b_cnt++;
        end
        b_fire = AXI_BVALID && AXI_BREADY;
        if (r_active && !AXI_RVALID) begin
          if (r_cnt >= r_cur) begin AXI_RVALID = 1; AXI_RDATA = r_data; AXI_RRESP = r_resp; end else r_cnt++;
        end
        r_fire = AXI_RVALID && AXI_RREADY;

        AXI_AWREADY = 0;
        if (AXI_AWVALID) begin
          aw_vcyc++;
          if (aw_have) proto_err++;
          else begin
            if (!aw_wait) begin
              aw_wait = 1; aw_cnt = 0; aw_cur = pick(aw_lat);
              if (aw_first < 0) aw_first = cyc;
            end else if (AXI_AWADDR != aw_a) stable_err++;
            aw_a = AXI_AWADDR;
            if (aw_cnt >= aw_cur) begin AXI_AWREADY = 1; aw_wait = 0; aw_have = 1; aw_hs_c = cyc; end
            else aw_cnt++;
          end
        end

        AXI_WREADY = 0;
        if (AXI_WVALID) begin
          w_vcyc++;
          if (w_have) proto_err++;
          else begin
            if (!w_wait) begin w_wait = 1; w_cnt = 0; w_cur = pick(w_lat); end
            else if (AXI_WDATA != w_d || AXI_WSTRB != w_s) stable_err++;
            w_d = AXI_WDATA; w_s = AXI_WSTRB;
            if (w_cnt >= w_cur) begin AXI_WREADY = 1; w_wait = 0; w_have = 1; w_hs_c = cyc; end
            else w_cnt++;
          end
        end

        AXI_ARREADY = 0;
        if (AXI_ARVALID) begin
          ar_vcyc++;
          if (ar_have) proto_err++;
          else begin
            if (!ar_wait) begin
              ar_wait = 1; ar_cnt = 0; ar_cur = pick(ar_lat);
              if (ar_first < 0) ar_first = cyc;
            end else if (AXI_ARADDR != ar_a) stable_err++;
            ar_a = AXI_ARADDR;
            if (ar_cnt >= ar_cur) begin
              AXI_ARREADY = 1; ar_wait = 0; ar_have = 1; ar_hs_c = cyc;
              check_eq("araddr", 32'(ar_a), 32'(exp_addr));
              k = int'(ar_a[15:2]);
              r_data = slv_get(k); r_resp = resp_of(ar_a); r_start = 1;
            end else ar_cnt++;
          end
        end

        // Both halves of the write are in: commit it and schedule the B response.
        if (aw_have && w_have && !b_pend) begin
          check_eq("awaddr", 32'(aw_a), 32'(exp_addr));
          check_eq("wdata", w_d, exp_wdata);
          check_eq("wstrb", 32'(w_s), 32'(exp_wstrb));
          k = int'(aw_a[15:2]);
          word = slv_get(k);
          for (int i = 0; i < 4; i++) if (w_s[i]) word[8*i +: 8] = w_d[8*i +: 8];
          slv_mem[k] = word;
          b_resp = resp_of(aw_a); b_pend = 1; b_start = 1;
        end
      end
    end
  end

  // Issue one command and check its response against the reference model.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold, output int t_acc, output int t_rsp);
    logic [31:0] e_data, word;
    logic [1:0]  e_resp;
    int n, k;
    aw_first = -1; ar_first = -1; aw_hs_c = -1; w_hs_c = -1; ar_hs_c = -1; bready_first = -1;
    aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0;
    exp_addr = a; exp_wdata = d; exp_wstrb = s;
    req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < TIMEOUT) begin @(negedge clk); n++; end
    check_eq("req_accept", 32'(req_ready), 32'd1);
    t_acc = cyc;
    k = int'(a[15:2]);
    if (a[1:0] != 2'b00) begin
      e_data = '0; e_resp = 2'b10;
    end else if (wr) begin
      word = ref_get(k);
      for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
      ref_mem[k] = word;
      e_data = '0; e_resp = resp_of(a);
    end else begin
      e_data = ref_get(k); e_resp = resp_of(a);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < TIMEOUT) begin @(negedge clk); n++; end
    t_rsp = cyc;
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_rdata", rsp_rdata, e_data);
    check_eq("rsp_resp", 32'(rsp_resp), 32'(e_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, e_data);
      check_eq("hold_resp", 32'(rsp_resp), 32'(e_resp));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    check_eq("req_ready_respond", 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ta, tr, nv;
    logic [AW-1:0] a;
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_axi_valids", {28'd0, AXI_AWVALID, AXI_WVALID, AXI_ARVALID, 1'b0}, 32'd0);
    check_eq("rst_axi_readys", {30'd0, AXI_BREADY, AXI_RREADY}, 32'd0);
    check_eq("rst_rsp_data", rsp_rdata, 32'd0);
    check_eq("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check_eq("rst_addr_data", {16'(AXI_AWADDR), 16'(AXI_WDATA[15:0])}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Minimum-latency write.
    run_cmd(1'b1, 16'h4000, 32'h12345678, 4'hF, 0, ta, tr);
    check_eq("w1_aw_first", 32'(aw_first), 32'(ta + 1));
    check_eq("w1_aw_hs", 32'(aw_hs_c), 32'(ta + 1));
    check_eq("w1_w_hs", 32'(w_hs_c), 32'(ta + 1));
    check_eq("w1_bready", 32'(bready_first), 32'(ta + 2));
    check_eq("w1_rsp_t", 32'(tr), 32'(ta + 3));

    // Read with ARREADY held off three cycles.
    ref_mem[int'(16'hBFF8 >> 2)] = 32'h0000002A;
    slv_mem[int'(16'hBFF8 >> 2)] = 32'h0000002A;
    ar_lat = 3;
    run_cmd(1'b0, 16'hBFF8, 32'h0, 4'h0, 0, ta, tr);
    ar_lat = 0;
    check_eq("r2_ar_first", 32'(ar_first), 32'(ta + 1));
    check_eq("r2_ar_cycles", 32'(ar_vcyc), 32'd4);
    check_eq("r2_ar_hs", 32'(ar_hs_c), 32'(ta + 4));
    check_eq("r2_rsp_t", 32'(tr), 32'(ta + 6));

    // Write with AWREADY late and WREADY immediate.
    aw_lat = 2;
    run_cmd(1'b1, 16'h4100, 32'hCAFEF00D, 4'h5, 0, ta, tr);
    aw_lat = 0;
    check_eq("w3_w_cycles", 32'(w_vcyc), 32'd1);
    check_eq("w3_w_hs", 32'(w_hs_c), 32'(ta + 1));
    check_eq("w3_aw_cycles", 32'(aw_vcyc), 32'd3);
    check_eq("w3_aw_hs", 32'(aw_hs_c), 32'(ta + 3));
    check_eq("w3_bready", 32'(bready_first), 32'(ta + 4));
    check_eq("w3_rsp_t", 32'(tr), 32'(ta + 5));

    // Misaligned commands never reach the bus.
    nv = axi_valid_cycles;
    run_cmd(1'b1, 16'h4002, 32'hFFFFFFFF, 4'hF, 0, ta, tr);
    check_eq("m4_rsp_t", 32'(tr), 32'(ta + 1));
    run_cmd(1'b0, 16'h4003, 32'h0, 4'h0, 1, ta, tr);
    check_eq("m4_read_rsp_t", 32'(tr), 32'(ta + 1));
    check_eq("m4_no_axi", 32'(axi_valid_cycles), 32'(nv));

    // Unmapped read with a slow consumer.
    run_cmd(1'b0, 16'h8000, 32'h0, 4'h0, 5, ta, tr);

    // Reset in the middle of a write address phase.
    aw_lat = 10;
    exp_addr = 16'h4200; exp_wdata = 32'hDEADBEEF; exp_wstrb = 4'hF;
    req_write = 1'b1; req_addr = 16'h4200; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rst_pre_awvalid", 32'(AXI_AWVALID), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_awvalid", 32'(AXI_AWVALID), 32'd0);
    check_eq("rst_async_wvalid", 32'(AXI_WVALID), 32'd0);
    check_eq("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_async_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; aw_lat = 0;
    @(negedge clk);
    check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);
    run_cmd(1'b0, 16'h4000, 32'h0, 4'h0, 0, ta, tr);
    check_eq("post_rst_rsp_t", 32'(tr), 32'(ta + 3));
    run_cmd(1'b0, 16'h4100, 32'h0, 4'h0, 0, ta, tr);
    run_cmd(1'b0, 16'h4200, 32'h0, 4'h0, 0, ta, tr);

    // Random traffic with random slave and consumer timing.
    aw_lat = -1; w_lat = -1; ar_lat = -1; b_lat = -1; r_lat = -1;
    for (int i = 0; i < 80; i++) begin
      a = {4'($urandom_range(0, 15)), 6'h00, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run_cmd(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), ta, tr);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check_eq("protocol_errors", 32'(proto_err), 32'd0);
    check_eq("stability_errors", 32'(stable_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
